// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: instruction kinds and pipeline slot type shared by the scoreboard
package hazard_scoreboard_pkg;
    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [1:0] KIND_LONG = 2'd2;

    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [4:0] rd;
        logic [1:0] kind;
    } slot_t;

    function automatic logic slot_writes(slot_t s);
        return s.valid & s.wen & (s.rd != 5'd0);
    endfunction
endpackage

// File: rtl/hazard_scoreboard_busy_table.sv
// hazard_scoreboard_busy_table: long-op busy bits with same-cycle completion bypass and outstanding count
module hazard_scoreboard_busy_table #(
    parameter int LONG_MAX = 2,
    parameter int NREG     = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_set,
    input  logic [$clog2(NREG)-1:0]       i_set_rd,
    input  logic                          i_clr,
    input  logic [$clog2(NREG)-1:0]       i_clr_rd,
    output logic [NREG-1:0]               o_busy_eff,
    output logic [$clog2(LONG_MAX+1)-1:0] o_long_cnt
);
    localparam int CW = $clog2(LONG_MAX + 1);

    logic [NREG-1:0] r_busy, w_set_mask, w_clr_mask;
    logic [CW-1:0]   r_long_cnt;
    logic            w_clr_hit;

    always_comb begin
        w_set_mask = i_set ? NREG'(1) << i_set_rd : '0;
        w_clr_mask = i_clr ? NREG'(1) << i_clr_rd : '0;
        w_clr_hit  = |(r_busy & w_clr_mask);
        o_busy_eff = r_busy & ~w_clr_mask;
        o_long_cnt = r_long_cnt;
    end

    // set applied after clear: a new op to the same register outlives the old completion
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy     <= '0;
            r_long_cnt <= '0;
        end else begin
            r_busy     <= o_busy_eff | w_set_mask;
            r_long_cnt <= r_long_cnt + CW'(i_set) - CW'(w_clr_hit);
        end
    end

    a_done_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_clr |-> w_clr_hit);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MA/WB write-tag pipe and ID stall for hazards the bypass network cannot cover
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int LONG_MAX = 2,
    parameter int NREG     = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_hold,
    input  logic                          i_flush,
    input  logic                          i_id_valid,
    input  logic [4:0]                    i_id_rs1,
    input  logic [4:0]                    i_id_rs2,
    input  logic [4:0]                    i_id_rd,
    input  logic                          i_id_wen,
    input  logic [1:0]                    i_id_kind,
    input  logic                          i_long_done,
    input  logic [4:0]                    i_long_rd,
    output logic                          o_id_stall,
    output logic [4:0]                    o_ex_rd,
    output logic [4:0]                    o_ma_rd,
    output logic [4:0]                    o_wb_rd,
    output logic [$clog2(LONG_MAX+1)-1:0] o_long_cnt
);
    localparam slot_t BUBBLE = '{valid: 1'b0, wen: 1'b0, rd: 5'd0, kind: KIND_ALU};

    slot_t           r_ex, r_ma, r_wb, w_id;
    logic [NREG-1:0] w_busy_eff;
    logic            w_ex_wr, w_ex_long, w_load_use, w_raw, w_waw, w_cap, w_issue, w_set;

    always_comb begin
        w_id       = '{valid: 1'b1, wen: i_id_wen, rd: i_id_rd, kind: i_id_kind};
        w_ex_wr    = slot_writes(r_ex);
        w_ex_long  = w_ex_wr & (r_ex.kind == KIND_LONG);
        w_load_use = w_ex_wr & (r_ex.kind != KIND_ALU) & ((i_id_rs1 == r_ex.rd) | (i_id_rs2 == r_ex.rd));
        w_raw      = w_busy_eff[i_id_rs1] | w_busy_eff[i_id_rs2];
        w_waw      = i_id_wen & w_busy_eff[i_id_rd];
        w_cap      = (i_id_kind == KIND_LONG) & (int'(o_long_cnt) + int'(w_ex_long) >= LONG_MAX);
        o_id_stall = i_id_valid & (i_hold | w_load_use | w_raw | w_waw | w_cap);
        w_issue    = i_id_valid & ~o_id_stall & ~i_flush;
        w_set      = ~i_hold & ~i_flush & w_ex_long;
        o_ex_rd    = w_ex_wr ? r_ex.rd : 5'd0;
        o_ma_rd    = slot_writes(r_ma) & (r_ma.kind != KIND_LONG) ? r_ma.rd : 5'd0;
        o_wb_rd    = slot_writes(r_wb) & (r_wb.kind != KIND_LONG) ? r_wb.rd : 5'd0;
    end

    // flush still kills EX during a hold; x0 never reaches the busy table so it never stalls
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ex <= BUBBLE;
            r_ma <= BUBBLE;
            r_wb <= BUBBLE;
        end else begin
            if (!i_hold) begin
                r_wb <= r_ma;
                r_ma <= i_flush ? BUBBLE : r_ex;
            end
            if (!i_hold || i_flush) r_ex <= w_issue ? w_id : BUBBLE;
        end
    end

    hazard_scoreboard_busy_table #(.LONG_MAX(LONG_MAX), .NREG(NREG)) u_busy (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_set      (w_set),
        .i_set_rd   (r_ex.rd),
        .i_clr      (i_long_done),
        .i_clr_rd   (i_long_rd),
        .o_busy_eff (w_busy_eff),
        .o_long_cnt (o_long_cnt)
    );
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed test-plan scenarios plus random traffic against an instruction-level model
module tb_hazard_scoreboard;
    localparam int LONG_MAX = 2;

    logic       clk = 0, rst_n = 0, hold = 0, flush = 0, id_valid = 0, id_wen = 0, long_done = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0, long_rd = 0;
    logic [1:0] id_kind = 0;
    logic       id_stall;
    logic [4:0] ex_rd, ma_rd, wb_rd;
    logic [1:0] long_cnt;

    int n_err = 0, n_chk = 0;
    bit obs_stall;

    typedef struct {bit v; bit w; int rd; int k;} ins_t;
    ins_t mex, mma, mwb;
    int   pend[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.LONG_MAX(LONG_MAX), .NREG(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
        .i_id_wen(id_wen), .i_id_kind(id_kind), .i_long_done(long_done), .i_long_rd(long_rd),
        .o_id_stall(id_stall), .o_ex_rd(ex_rd), .o_ma_rd(ma_rd), .o_wb_rd(wb_rd),
        .o_long_cnt(long_cnt)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic ins_t bub();
        ins_t b;
        b = '{0, 0, 0, 0};
        return b;
    endfunction

    function automatic int mtag(ins_t s, bit late);
        return (s.v && s.w && s.rd != 0 && !(late && s.k == 2)) ? s.rd : 0;
    endfunction

    function automatic bit in_pend(int r);
        foreach (pend[i]) if (pend[i] == r) return 1;
        return 0;
    endfunction

    function automatic bit busy(int r);
        return r != 0 && in_pend(r) && !(long_done && int'(long_rd) == r);
    endfunction

    function automatic bit exp_stall();
        int e;
        if (!id_valid) return 0;
        if (hold) return 1;
        e = mtag(mex, 0);
        if (e != 0 && mex.k != 0 && (int'(id_rs1) == e || int'(id_rs2) == e)) return 1;
        if (busy(int'(id_rs1)) || busy(int'(id_rs2))) return 1;
        if (id_wen && busy(int'(id_rd))) return 1;
        if (id_kind == 2 && pend.size() + ((e != 0 && mex.k == 2) ? 1 : 0) >= LONG_MAX) return 1;
        return 0;
    endfunction

    task automatic step(input bit v, input int r1, input int r2, input int d, input bit w, input int k,
                        input bit h, input bit f, input bit dn, input int drd);
        bit es;
        @(negedge clk);
        id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(d); id_wen = w; id_kind = 2'(k);
        hold = h; flush = f; long_done = dn; long_rd = 5'(drd);
        #1;
        es = exp_stall();
        obs_stall = id_stall;
        chk("stall", int'(id_stall), int'(es));
        chk("ex_rd", int'(ex_rd), mtag(mex, 0));
        chk("ma_rd", int'(ma_rd), mtag(mma, 1));
        chk("wb_rd", int'(wb_rd), mtag(mwb, 1));
        chk("long_cnt", int'(long_cnt), pend.size());
        @(posedge clk);
        if (dn)
            for (int i = 0; i < pend.size(); i++)
                if (pend[i] == drd) begin
                    pend.delete(i);
                    break;
                end
        if (!h) begin
            if (!f && mtag(mex, 0) != 0 && mex.k == 2) pend.push_back(mex.rd);
            mwb = mma;
            if (f) mma = bub(); else mma = mex;
        end
        if (!h || f) begin
            if (v && !es && !f) mex = '{1'b1, w, d, k}; else mex = bub();
        end
        #1;
    endtask

    initial begin
        int k, d, r1, r2, drd;
        bit w, dn;
        mex = bub(); mma = bub(); mwb = bub();
        rst_n = 0; id_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex", int'(ex_rd), 0);
        chk("rst_ma", int'(ma_rd), 0);
        chk("rst_wb", int'(wb_rd), 0);
        chk("rst_cnt", int'(long_cnt), 0);
        rst_n = 1; id_valid = 0;

        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); chk("alu_ex5", int'(ex_rd), 5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("alu_ma5", int'(ma_rd), 5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("alu_wb5", int'(wb_rd), 5);

        step(1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        step(1, 7, 0, 8, 1, 0, 0, 0, 0, 0); chk("lu_stall", int'(obs_stall), 1);
        chk("lu_bubble", int'(ex_rd), 0); chk("lu_ma7", int'(ma_rd), 7);
        step(1, 7, 0, 8, 1, 0, 0, 0, 0, 0); chk("lu_go", int'(obs_stall), 0);
        chk("lu_ex8", int'(ex_rd), 8);

        step(1, 0, 0, 9, 1, 2, 0, 0, 0, 0);
        step(1, 9, 0, 10, 1, 0, 0, 0, 0, 0); chk("div_ex_stall", int'(obs_stall), 1);
        chk("div_cnt1", int'(long_cnt), 1);
        step(1, 9, 0, 10, 1, 0, 0, 0, 0, 0); chk("div_busy_stall", int'(obs_stall), 1);
        step(1, 9, 0, 10, 1, 0, 0, 0, 1, 9); chk("div_release", int'(obs_stall), 0);
        chk("div_cnt0", int'(long_cnt), 0); chk("div_ex10", int'(ex_rd), 10);

        step(1, 0, 0, 1, 1, 2, 0, 0, 0, 0);
        step(1, 0, 0, 2, 1, 2, 0, 0, 0, 0); chk("cap_2nd", int'(obs_stall), 0);
        step(1, 0, 0, 3, 1, 2, 0, 0, 0, 0); chk("cap_3rd_a", int'(obs_stall), 1);
        step(1, 0, 0, 3, 1, 2, 0, 0, 0, 0); chk("cap_3rd_b", int'(obs_stall), 1);
        step(1, 0, 0, 3, 1, 2, 0, 0, 1, 1); chk("cap_3rd_c", int'(obs_stall), 1);
        step(1, 0, 0, 3, 1, 2, 0, 0, 0, 0); chk("cap_issue", int'(obs_stall), 0);
        chk("cap_ex3", int'(ex_rd), 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3); chk("cap_drain", int'(long_cnt), 0);

        step(1, 0, 0, 4, 1, 2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("fl_ma0", int'(ma_rd), 0); chk("fl_cnt0", int'(long_cnt), 0);
        step(1, 4, 0, 11, 1, 0, 0, 0, 0, 0); chk("fl_reader", int'(obs_stall), 0);

        step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 6, 1, 0, 1, 0, 0, 0);
            chk("hold_stall", int'(obs_stall), 1);
            chk("hold_ex", int'(ex_rd), 3); chk("hold_ma", int'(ma_rd), 2); chk("hold_wb", int'(wb_rd), 1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rel_ex", int'(ex_rd), 0); chk("rel_ma", int'(ma_rd), 3); chk("rel_wb", int'(wb_rd), 2);

        for (int c = 0; c < 800; c++) begin
            k = $urandom % 3;
            r1 = $urandom % 8;
            r2 = $urandom % 8;
            d = $urandom % 8;
            w = ($urandom % 4) != 0;
            if (k == 2) begin
                w = 1;
                do d = 1 + $urandom % 7; while (in_pend(d) || (mtag(mex, 0) == d && mex.k == 2));
            end
            dn = 0;
            drd = 0;
            if (pend.size() > 0 && $urandom % 3 == 0) begin
                dn = 1;
                drd = pend[$urandom % pend.size()];
            end
            step(($urandom % 4) != 0, r1, r2, d, w, k, ($urandom % 8) == 0, ($urandom % 8) == 0, dn, drd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
